// File: rtl/fetch_sequencer.sv
// Next-PC selection and IF/ID control for the 5-stage pipeline front end.
// Chooses hold / sequential / redirect each cycle and defers redirects that land during an imem wait.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_STEP      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  input  logic        imem_busy,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        ifid_write,
  output logic        ifid_flush
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    REDIR = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] redir_target_q, redir_target_d;
  logic [31:0] pc_seq;

  assign pc_seq    = pc_cur + 32'(PC_STEP);
  assign imem_addr = pc_cur;

  // State and deferred-redirect registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= FETCH;
      redir_target_q <= 32'h0;
    end else begin
      state_q        <= state_d;
      redir_target_q <= redir_target_d;
    end
  end

  // Next-state and output decode; FETCH and WAIT share one decision table.
  always_comb begin
    state_d        = state_q;
    redir_target_d = redir_target_q;
    pc_next        = pc_cur;
    imem_read      = 1'b1;
    ifid_write     = 1'b0;
    ifid_flush     = 1'b0;

    if (reset) begin
      pc_next    = RESET_VECTOR;
      imem_read  = 1'b0;
      ifid_flush = 1'b1;
    end else begin
      unique case (state_q)
        FETCH, WAIT: begin
          if (branch_taken) begin
            ifid_flush = 1'b1;
            if (imem_busy) begin
              redir_target_d = branch_target;
              state_d        = REDIR;
            end else begin
              pc_next = branch_target;
              state_d = FETCH;
            end
          end else if (imem_busy) begin
            state_d = WAIT;
          end else if (stall) begin
            state_d = FETCH;
          end else begin
            pc_next    = pc_seq;
            ifid_write = 1'b1;
            state_d    = FETCH;
          end
        end
        REDIR: begin
          // The in-flight fetch is discarded; a newer branch replaces the pending target.
          ifid_flush = 1'b1;
          if (branch_taken) begin
            redir_target_d = branch_target;
          end
          if (!imem_busy) begin
            pc_next = branch_taken ? branch_target : redir_target_q;
            state_d = FETCH;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed test-plan scenarios followed by random traffic.
module tb_fetch_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc_next;
    logic [31:0] addr;
    logic        read;
    logic        wr;
    logic        flush;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_cur = RV;
  logic [31:0] pc_next;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic        imem_busy = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        ifid_write;
  logic        ifid_flush;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb_q[$];
  bit   stim_done = 1'b0;

  // Reference model: a PC register plus an optional pending redirect.
  logic [31:0] m_pc = RV;
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_tgt = 32'h0;

  fetch_sequencer #(.RESET_VECTOR(RV), .PC_STEP(4)) dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .pc_next(pc_next),
    .imem_read(imem_read), .imem_addr(imem_addr), .imem_busy(imem_busy),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string field, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h at %0t", tag, field, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push the expected response.
  task automatic cycle(input string tag, input bit rst, input bit br, input bit busy,
                       input bit stl, input logic [31:0] tgt);
    exp_t e;
    @(posedge clk);
    #1;
    pc_cur        = rst ? RV : m_pc;
    reset         = rst;
    branch_taken  = br;
    imem_busy     = busy;
    stall         = stl;
    branch_target = tgt;

    e.tag   = tag;
    e.addr  = pc_cur;
    e.read  = 1'b1;
    e.wr    = 1'b0;
    e.flush = 1'b0;
    e.pc_next = pc_cur;
    if (rst) begin
      e.pc_next = RV;
      e.read    = 1'b0;
      e.flush   = 1'b1;
      m_pend    = 1'b0;
    end else if (m_pend) begin
      e.flush = 1'b1;
      if (br) m_pend_tgt = tgt;
      if (!busy) begin
        e.pc_next = m_pend_tgt;
        m_pend    = 1'b0;
      end
    end else if (br) begin
      e.flush = 1'b1;
      if (busy) begin
        m_pend     = 1'b1;
        m_pend_tgt = tgt;
      end else begin
        e.pc_next = tgt;
      end
    end else if (!busy && !stl) begin
      e.pc_next = pc_cur + 32'd4;
      e.wr      = 1'b1;
    end
    m_pc = e.pc_next;
    sb_q.push_back(e);
  endtask

  task automatic run(input string tag, input int n, input bit busy, input bit stl);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, busy, stl, 32'h0);
  endtask

  // Monitor: compares outputs against the scoreboard once per cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.tag, "pc_next",   pc_next,             e.pc_next);
        check(e.tag, "imem_addr", imem_addr,           e.addr);
        check(e.tag, "imem_read", 32'(imem_read),      32'(e.read));
        check(e.tag, "ifid_write", 32'(ifid_write),    32'(e.wr));
        check(e.tag, "ifid_flush", 32'(ifid_flush),    32'(e.flush));
      end
    end
  end

  initial begin
    int budget;
    // Reset, free run, asynchronous reset mid-run.
    cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    run("free", 4, 1'b0, 1'b0);
    cycle("reset_mid", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    run("after_reset", 2, 1'b0, 1'b0);

    // Branch with idle memory.
    m_pc = 32'h10;
    cycle("branch", 1'b0, 1'b1, 1'b0, 1'b0, 32'h40);
    run("post_branch", 2, 1'b0, 1'b0);

    // Memory wait.
    m_pc = 32'h20;
    run("wait", 3, 1'b1, 1'b0);
    run("wait_done", 2, 1'b0, 1'b0);

    // Branch during a wait, resolved after busy releases.
    m_pc = 32'h20;
    run("wait2", 1, 1'b1, 1'b0);
    cycle("br_busy", 1'b0, 1'b1, 1'b1, 1'b0, 32'h80);
    run("redir_busy", 2, 1'b1, 1'b0);
    run("redir_done", 3, 1'b0, 1'b0);

    // Stall, stall with branch, wrap-around.
    m_pc = 32'h30;
    run("stall", 2, 1'b0, 1'b1);
    cycle("stall_br", 1'b0, 1'b1, 1'b0, 1'b1, 32'h100);
    m_pc = 32'hFFFF_FFFC;
    run("wrap", 2, 1'b0, 1'b0);

    // Latest-wins redirect and stall ignored while redirecting.
    m_pc = 32'h60;
    cycle("br_busy2", 1'b0, 1'b1, 1'b1, 1'b0, 32'h300);
    cycle("redir_rebr", 1'b0, 1'b1, 1'b1, 1'b1, 32'h304);
    cycle("redir_rebr_rel", 1'b0, 1'b1, 1'b0, 1'b1, 32'h308);
    run("after_rebr", 2, 1'b0, 1'b0);

    // Reset while a redirect to 0x200 is pending.
    m_pc = 32'h50;
    cycle("br_busy3", 1'b0, 1'b1, 1'b1, 1'b0, 32'h200);
    run("redir_hold", 1, 1'b1, 1'b0);
    cycle("reset_redir", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    run("post_reset_busy", 2, 1'b1, 1'b0);
    run("post_reset", 3, 1'b0, 1'b0);

    // Random traffic, including misaligned targets and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) m_pc = $urandom;
      cycle("random", $urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom);
    end
    reset = 1'b0; branch_taken = 1'b0; imem_busy = 1'b0; stall = 1'b0;

    budget = 0;
    while (sb_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    check("drain", "pending", 32'(sb_q.size()), 32'd0);
    stim_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controller that sequences the program counter register and instruction fetch in the RV32IM 5-stage pipeline. The PC register loads its input on every clock, so this block computes that next value every cycle, choosing between hold, PC+4 and redirect. It also handles multi-cycle instruction-memory waits, hazard stalls and EX-stage branch/jump redirects, and drives write-enable and flush for the IF/ID pipeline register.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value forced on pc_next during reset; must equal the PC register's reset value.
PC_STEP, 4, sequential fetch increment in bytes.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
pc_cur  input  32  current PC from the PC register output
pc_next  output  32  next PC, drives the PC register input
imem_read  output  1  instruction-memory read request
imem_addr  output  32  fetch address, always equal to pc_cur
imem_busy  input  1  instruction memory has not finished the current read
stall  input  1  hazard-unit request to hold IF (load-use)
branch_taken  input  1  EX-stage redirect valid (taken branch, JAL or JALR)
branch_target  input  32  redirect address, valid with branch_taken
ifid_write  output  1  IF/ID register load enable
ifid_flush  output  1  IF/ID register clear (insert bubble)

Behaviour:
- FSM states are FETCH, WAIT and REDIR. Registers are state and redir_target[31:0]. All outputs are combinational from state, registers and inputs.
- Reset (asynchronous) puts the block in FETCH with redir_target=0.
- While reset is high, the outputs are pc_next=RESET_VECTOR, imem_read=0, ifid_write=0 and ifid_flush=1.
- Outside reset, imem_read=1 in every state and imem_addr=pc_cur.
- pc_next is pc_cur+PC_STEP using 32-bit modulo arithmetic, so 32'hFFFF_FFFC wraps to 0. Other values are pc_cur (hold), branch_target or redir_target.
- Priority is branch_taken > imem_busy > stall. In every case where ifid_flush=1, ifid_write=0.
- FETCH:
  - branch_taken and !imem_busy: pc_next=branch_target, ifid_flush=1, stay in FETCH.
  - branch_taken and imem_busy: redir_target<=branch_target, pc_next=pc_cur, ifid_flush=1, go to REDIR.
  - imem_busy: pc_next=pc_cur, ifid_write=0, go to WAIT.
  - stall: pc_next=pc_cur, ifid_write=0, stay in FETCH.
  - otherwise: pc_next=pc_cur+PC_STEP, ifid_write=1, stay in FETCH.
- WAIT uses the same decision table as FETCH, with these transitions:
  - branch_taken and imem_busy: go to REDIR.
  - branch_taken and !imem_busy: go to FETCH.
  - imem_busy: stay in WAIT.
  - !imem_busy and stall: hold pc_next, ifid_write=0, go to FETCH; the instruction memory is re-read, which is side-effect free.
  - !imem_busy and !stall: pc+4, ifid_write=1, go to FETCH.
- REDIR:
  - Every cycle: ifid_flush=1, ifid_write=0. The in-flight fetch is discarded.
  - imem_busy: pc_next=pc_cur, stay in REDIR.
  - !imem_busy: pc_next=redir_target, go to FETCH.
  - branch_taken in REDIR: redir_target is overwritten with branch_target (latest wins), and the completion rule still applies. If !imem_busy in the same cycle, pc_next=branch_target.
  - stall is ignored in REDIR.
- Redirect latency: a taken branch with !imem_busy makes pc_cur equal branch_target one clock later. With imem_busy, pc_cur equals the target one clock after the first cycle imem_busy is low.
- Reset asserted in any state, including mid-REDIR, discards redir_target immediately and restarts at RESET_VECTOR. No partial redirect survives.
- A misaligned branch_target (bits[1:0]≠0) is passed through unchanged; the exception is raised elsewhere.

Test Plan:
- Reset then free run (imem_busy=0, stall=0): pc_next sequence 0x4, 0x8, 0xC; ifid_write=1 each cycle; ifid_flush=0; reset mid-run returns pc_next to 0x0 asynchronously.
- Branch with pc_cur=0x10, branch_taken=1, branch_target=0x40, imem_busy=0: same cycle pc_next=0x40, ifid_flush=1; next cycle pc_cur=0x40, pc_next=0x44.
- Hold pc_cur=0x20 with imem_busy=1 for 3 cycles: state WAIT, pc_next=0x20, ifid_write=0. When imem_busy falls: pc_next=0x24, ifid_write=1, state FETCH.
- Branch during wait: pc_cur=0x20, imem_busy=1, branch_taken pulse to 0x80, busy for 2 more cycles. Required: state REDIR, ifid_flush=1 throughout, pc_next=0x20 while busy, pc_next=0x80 on busy release, then 0x84 the cycle after.
- Stall and wrap: stall=1 at pc_cur=0x30 for 2 cycles gives pc_next=0x30 and ifid_write=0. stall together with branch_taken (target 0x100) gives pc_next=0x100 and ifid_flush=1. pc_cur=0xFFFF_FFFC with no events gives pc_next=0x0.
- Reset in REDIR with redir_target=0x200: assert reset; pc_next=RESET_VECTOR immediately. After release, state is FETCH and 0x200 is never output.
